// File: rtl/tpu_tile_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tpu_tile_sequencer
// Description : Job sequencer for one systolic-array tile. A job does the
//               following in order:
//                 1. fetch one weight-SRAM entry,
//                 2. reload the array weights,
//                 3. stream num_rows activation rows from the unified buffer,
//                 4. write each deskewed result word RESULT_LAT cycles after
//                    the matching read,
//                 5. pulse done.
//               Every output is a flop.
// Ports       : clk, rstn              - clock, async active-low reset
//               start, num_rows,       - job request and job descriptor
//               src_base, dst_base,    -   (sampled only while idle)
//               w_sel
//               busy, done, err        - job status
//               ub_rd_en, ub_addr      - unified-buffer read port
//               w_addr, we_rl          - weight-SRAM address, weight reload
//               res_we, res_addr       - result-SRAM write port
//               perf_cycles            - busy cycles of the last job
//                                        (only with TILE_SEQ_PERF_EN)
// Config      : define TILE_SEQ_PERF_EN to add the perf_cycles counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tpu_tile_sequencer #(
    parameter int MATRIX_SIZE   = 8,
    parameter int ADDRESSSIZE   = 10,
    parameter int W_ADDRESSSIZE = 2,
    parameter int RESULT_LAT    = 2*MATRIX_SIZE+2
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     start,
    input  logic [ADDRESSSIZE:0]     num_rows,
    input  logic [ADDRESSSIZE-1:0]   src_base,
    input  logic [ADDRESSSIZE-1:0]   dst_base,
    input  logic [W_ADDRESSSIZE-1:0] w_sel,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic                     ub_rd_en,
    output logic [ADDRESSSIZE-1:0]   ub_addr,
    output logic [W_ADDRESSSIZE-1:0] w_addr,
    output logic                     we_rl,
    output logic                     res_we,
`ifdef TILE_SEQ_PERF_EN
    output logic [31:0]              perf_cycles,
`endif
    output logic [ADDRESSSIZE-1:0]   res_addr
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WFETCH = 3'd1;
    localparam logic [2:0] S_WLOAD  = 3'd2;
    localparam logic [2:0] S_STREAM = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;
    localparam logic [2:0] S_FINISH = 3'd5;

    logic [2:0]               state_q, state_d;
    logic [ADDRESSSIZE:0]     rows_q;
    logic [ADDRESSSIZE-1:0]   src_q;
    logic [ADDRESSSIZE:0]     rd_cnt_q;
    logic [ADDRESSSIZE:0]     wr_cnt_q;
    logic [RESULT_LAT-1:0]    dly_q;
    logic                     busy_q, done_q, err_q, ub_rd_en_q, we_rl_q;
    logic [ADDRESSSIZE-1:0]   ub_addr_q, res_addr_q;
    logic [W_ADDRESSSIZE-1:0] w_addr_q;
    logic                     accept, reject, wr_done, res_we_q;

    // Tail of the read-to-write delay line.
    assign res_we_q = dly_q[RESULT_LAT-1];

    // The write that happens this cycle counts, so DRAIN ends on the
    // cycle of the last result write.
    assign wr_done = (wr_cnt_q == rows_q) ||
                     (res_we_q && ((wr_cnt_q + 1'b1) == rows_q));

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        reject  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (num_rows != '0) begin
                        accept  = 1'b1;
                        state_d = S_WFETCH;
                    end else begin
                        reject  = 1'b1;
                    end
                end
            end
            S_WFETCH: state_d = S_WLOAD;
            S_WLOAD:  state_d = S_STREAM;
            S_STREAM: if (rd_cnt_q == rows_q - 1'b1) state_d = S_DRAIN;
            S_DRAIN:  if (wr_done) state_d = S_FINISH;
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            rows_q     <= '0;
            src_q      <= '0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            ub_rd_en_q <= 1'b0;
            we_rl_q    <= 1'b0;
            ub_addr_q  <= '0;
            res_addr_q <= '0;
            w_addr_q   <= '0;
        end else begin
            state_q    <= state_d;
            // Status and strobes are registered copies of the next state.
            busy_q     <= (state_d != S_IDLE);
            done_q     <= (state_d == S_FINISH);
            we_rl_q    <= (state_d == S_WLOAD);
            ub_rd_en_q <= (state_d == S_STREAM);
            err_q      <= reject;

            if (accept) begin
                rows_q     <= num_rows;
                src_q      <= src_base;
                w_addr_q   <= w_sel;
                res_addr_q <= dst_base;
                rd_cnt_q   <= '0;
                wr_cnt_q   <= '0;
            end else begin
                if (state_q == S_STREAM) rd_cnt_q <= rd_cnt_q + 1'b1;
                if (res_we_q) begin
                    wr_cnt_q   <= wr_cnt_q + 1'b1;
                    res_addr_q <= res_addr_q + 1'b1;
                end
            end

            // Address wraps naturally at 2^ADDRESSSIZE.
            if (state_d == S_STREAM)
                ub_addr_q <= (state_q == S_STREAM) ? ub_addr_q + 1'b1 : src_q;
        end
    end

    // Delay line from read strobe to result write strobe.
    generate
        if (RESULT_LAT == 1) begin : g_dly_one
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) dly_q <= '0;
                else       dly_q <= ub_rd_en_q;
            end
        end else begin : g_dly_multi
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) dly_q <= '0;
                else       dly_q <= {dly_q[RESULT_LAT-2:0], ub_rd_en_q};
            end
        end
    endgenerate

`ifdef TILE_SEQ_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                        perf_q <= '0;
        else if (accept)                  perf_q <= '0;
        else if (busy_q && perf_q != '1)  perf_q <= perf_q + 1'b1;
    end

    assign perf_cycles = perf_q;
`endif

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign ub_rd_en = ub_rd_en_q;
    assign ub_addr  = ub_addr_q;
    assign w_addr   = w_addr_q;
    assign we_rl    = we_rl_q;
    assign res_we   = res_we_q;
    assign res_addr = res_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_tpu_tile_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_tpu_tile_sequencer
// Description : Self-checking bench for tpu_tile_sequencer at default
//               parameters. It runs a table of jobs, then hand-written
//               sequences for:
//                 - start held high,
//                 - reset during STREAM.
//               Define TILE_SEQ_PERF_EN to also check perf_cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tpu_tile_sequencer;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [10:0] num_rows = '0;
    logic [9:0]  src_base = '0;
    logic [9:0]  dst_base = '0;
    logic [1:0]  w_sel = '0;
    logic        busy, done, err, ub_rd_en, we_rl, res_we;
    logic [9:0]  ub_addr, res_addr;
    logic [1:0]  w_addr;
`ifdef TILE_SEQ_PERF_EN
    logic [31:0] perf_cycles;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tpu_tile_sequencer dut (
        .clk(clk), .rstn(rstn), .start(start), .num_rows(num_rows),
        .src_base(src_base), .dst_base(dst_base), .w_sel(w_sel),
        .busy(busy), .done(done), .err(err), .ub_rd_en(ub_rd_en),
        .ub_addr(ub_addr), .w_addr(w_addr), .we_rl(we_rl), .res_we(res_we),
`ifdef TILE_SEQ_PERF_EN
        .perf_cycles(perf_cycles),
`endif
        .res_addr(res_addr)
    );

    typedef struct {
        logic [10:0] rows;
        logic [9:0]  src;
        logic [9:0]  dst;
        logic [1:0]  wsel;
        int          exp_w;
        int          exp_rd;
        int          exp_ub_first;
        int          exp_ub_last;
        int          exp_res_first;
        int          exp_res_last;
        int          exp_busy;
        int          exp_err;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int rd_n = 0, wr_n = 0, we_n = 0, busy_n = 0, done_n = 0, err_n = 0;
        int first_rd = -1, first_wr = -1, ub_first = -1, ub_last = -1;
        int res_first = -1, res_last = -1;
        int limit;
        bit seen_done = 0;
        logic [9:0] e;
        limit = (v.exp_err != 0) ? 6 : 200;
        @(negedge clk);
        start = 1'b1; num_rows = v.rows; src_base = v.src;
        dst_base = v.dst; w_sel = v.wsel;
        @(negedge clk);
        // Scramble the job inputs; the running job must not see this.
        start = 1'b0; num_rows = 11'd3; src_base = 10'h2AA;
        dst_base = 10'h155; w_sel = ~v.wsel;
        for (int cyc = 0; cyc < limit && !seen_done; cyc++) begin
            if (err) err_n++;
            if (busy) busy_n++;
            if (we_rl) we_n++;
            if (ub_rd_en) begin
                if (rd_n == 0) begin first_rd = cyc; ub_first = int'(ub_addr); end
                e = v.src + 10'(rd_n);
                chk($sformatf("v%0d ub_addr[%0d]", idx, rd_n), ub_addr, e);
                ub_last = int'(ub_addr);
                rd_n++;
            end
            if (res_we) begin
                if (wr_n == 0) begin first_wr = cyc; res_first = int'(res_addr); end
                e = v.dst + 10'(wr_n);
                chk($sformatf("v%0d res_addr[%0d]", idx, wr_n), res_addr, e);
                res_last = int'(res_addr);
                wr_n++;
            end
            if (done) begin done_n++; seen_done = 1; end
            @(negedge clk);
        end
        if (v.exp_err == 0) begin
            chk($sformatf("v%0d timeout", idx), seen_done, 1);
            chk($sformatf("v%0d busy_after_done", idx), busy, 0);
`ifdef TILE_SEQ_PERF_EN
            chk($sformatf("v%0d perf_cycles", idx), perf_cycles, v.exp_busy);
`endif
            chk($sformatf("v%0d latency", idx), first_wr - first_rd, 18);
            chk($sformatf("v%0d ub_first", idx), ub_first, v.exp_ub_first);
            chk($sformatf("v%0d ub_last", idx), ub_last, v.exp_ub_last);
            chk($sformatf("v%0d res_first", idx), res_first, v.exp_res_first);
            chk($sformatf("v%0d res_last", idx), res_last, v.exp_res_last);
        end
        chk($sformatf("v%0d w_addr", idx), w_addr, v.exp_w);
        chk($sformatf("v%0d rd_count", idx), rd_n, v.exp_rd);
        chk($sformatf("v%0d wr_count", idx), wr_n, v.exp_rd);
        chk($sformatf("v%0d we_rl_count", idx), we_n, (v.exp_err != 0) ? 0 : 1);
        chk($sformatf("v%0d busy_cycles", idx), busy_n, v.exp_busy);
        chk($sformatf("v%0d done_count", idx), done_n, (v.exp_err != 0) ? 0 : 1);
        chk($sformatf("v%0d err_count", idx), err_n, v.exp_err);
    endtask

    initial begin
        int we_n, bad_n;
        bit seen;
        // rows  src     dst     wsel w  rd ubF    ubL    resF   resL   busy err
        vecs[0] = '{11'd8,  10'h010, 10'h020, 2'd1, 1, 8,  'h010, 'h017, 'h020, 'h027, 29, 0};
        vecs[1] = '{11'd4,  10'h3FE, 10'h3FD, 2'd2, 2, 4,  'h3FE, 'h001, 'h3FD, 'h000, 25, 0};
        vecs[2] = '{11'd1,  10'h000, 10'h3FF, 2'd3, 3, 1,  'h000, 'h000, 'h3FF, 'h3FF, 22, 0};
        vecs[3] = '{11'd0,  10'h055, 10'h066, 2'd2, 3, 0,  0,     0,     0,     0,     0,  1};
        vecs[4] = '{11'd16, 10'h100, 10'h200, 2'd0, 0, 16, 'h100, 'h10F, 'h200, 'h20F, 37, 0};

        // Reset state
        #12;
        chk("rst busy", busy, 0);      chk("rst done", done, 0);
        chk("rst err", err, 0);        chk("rst ub_rd_en", ub_rd_en, 0);
        chk("rst ub_addr", ub_addr, 0); chk("rst w_addr", w_addr, 0);
        chk("rst we_rl", we_rl, 0);    chk("rst res_we", res_we, 0);
        chk("rst res_addr", res_addr, 0);
`ifdef TILE_SEQ_PERF_EN
        chk("rst perf", perf_cycles, 0);
`endif
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // Start held high: one acceptance, the next begins right after done.
        @(negedge clk);
        start = 1'b1; num_rows = 11'd2; src_base = 10'h000;
        dst_base = 10'h000; w_sel = 2'd2;
        @(negedge clk);
        w_sel = 2'd1;
        we_n = 0; seen = 0;
        for (int cyc = 0; cyc < 100 && !seen; cyc++) begin
            if (we_rl) we_n++;
            if (done) seen = 1;
            else begin
                if (cyc == 0) chk("held w_addr job1", w_addr, 2);
                @(negedge clk);
            end
        end
        chk("held timeout1", seen, 1);
        chk("held we_rl_count", we_n, 1);
        @(negedge clk);
        chk("held idle_after_done", busy, 0);
        @(negedge clk);
        chk("held second_accept", busy, 1);
        chk("held w_addr job2", w_addr, 1);
        start = 1'b0;
        seen = 0;
        for (int cyc = 0; cyc < 100 && !seen; cyc++) begin
            if (done) seen = 1;
            @(negedge clk);
        end
        chk("held timeout2", seen, 1);

        // Reset during STREAM
        @(negedge clk);
        start = 1'b1; num_rows = 11'd8; src_base = 10'h040;
        dst_base = 10'h080; w_sel = 2'd3;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
            if (ub_rd_en) seen = 1;
            else @(negedge clk);
        end
        chk("mid timeout", seen, 1);
        @(negedge clk);
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("mid busy", busy, 0);       chk("mid ub_rd_en", ub_rd_en, 0);
        chk("mid ub_addr", ub_addr, 0); chk("mid w_addr", w_addr, 0);
        chk("mid res_we", res_we, 0);   chk("mid res_addr", res_addr, 0);
        chk("mid we_rl", we_rl, 0);     chk("mid done", done, 0);
        @(negedge clk);
        rstn = 1'b1;
        bad_n = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (res_we || done || busy) bad_n++;
        end
        chk("post_reset activity", bad_n, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tpu_tile_sequencer.md
TPU_TILE_SEQUENCER -- requirements
Module: tpu_tile_sequencer

Interface
REQ-001 The block SHALL have parameter MATRIX_SIZE, default 8: systolic array edge (PE rows and columns).
REQ-002 The block SHALL have parameter ADDRESSSIZE, default 10: unified-buffer and result-SRAM address width.
REQ-003 The block SHALL have parameter W_ADDRESSSIZE, default 2: weight-SRAM address width.
REQ-004 The block SHALL have parameter RESULT_LAT, default 2*MATRIX_SIZE+2: cycles from ub_rd_en to the matching deskewed result word.
REQ-005 The block SHALL have port clk, input, 1 bit: the only clock.
REQ-006 The block SHALL have port rstn, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port start, input, 1 bit: job request, sampled only in IDLE.
REQ-008 The block SHALL have port num_rows, input, ADDRESSSIZE+1 bits: activation rows per job, legal range 1..2^ADDRESSSIZE.
REQ-009 The block SHALL have ports src_base and dst_base, input, ADDRESSSIZE bits each: first unified-buffer read address and first result write address.
REQ-010 The block SHALL have port w_sel, input, W_ADDRESSSIZE bits: weight-SRAM entry for the job.
REQ-011 The block SHALL have ports busy, done and err, output, 1 bit each: job active; 1-cycle completion pulse; 1-cycle illegal-job pulse.
REQ-012 The block SHALL have ports ub_rd_en, output, 1 bit, and ub_addr, output, ADDRESSSIZE bits: unified-buffer read strobe and address.
REQ-013 The block SHALL have ports w_addr, output, W_ADDRESSSIZE bits, and we_rl, output, 1 bit: weight-SRAM address and array weight reload.
REQ-014 The block SHALL have ports res_we, output, 1 bit, and res_addr, output, ADDRESSSIZE bits: result-SRAM write strobe and address.

Function
REQ-015 The FSM SHALL have states IDLE, WFETCH, WLOAD, STREAM, DRAIN and FINISH, all registered, with every output driven from registers.
REQ-016 In IDLE, start=1 with num_rows≠0 SHALL latch num_rows, src_base, dst_base and w_sel, then go to WFETCH.
REQ-017 In IDLE, start=1 with num_rows=0 SHALL pulse err for one cycle and stay in IDLE.
REQ-018 WFETCH SHALL last 1 cycle and drive w_addr=w_sel to cover the synchronous SRAM read; w_addr SHALL hold until the next job.
REQ-019 WLOAD SHALL last 1 cycle and assert we_rl; we_rl SHALL be 0 in every other state.
REQ-020 STREAM SHALL last exactly num_rows cycles with ub_rd_en=1; ub_addr SHALL be src_base+k on cycle k, modulo 2^ADDRESSSIZE (wrap-around).
REQ-021 res_we SHALL equal ub_rd_en delayed by exactly RESULT_LAT cycles through a shift register cleared on reset.
REQ-022 res_addr SHALL start at dst_base and increment modulo 2^ADDRESSSIZE after each res_we cycle.
REQ-023 DRAIN SHALL be entered after the last STREAM cycle and SHALL be left when the write count equals the latched num_rows.
REQ-024 FINISH SHALL last 1 cycle, pulse done and return to IDLE; the first start SHALL be accepted on the cycle after done.
REQ-025 busy SHALL be 1 in every state except IDLE; start SHALL be ignored while busy=1.
REQ-026 Changes to the job inputs while busy=1 SHALL have no effect on the job in progress.

Reset
REQ-027 On rstn=0 the FSM SHALL enter IDLE, clear all counters and the delay line, and drive every output to 0, asynchronously.
REQ-028 Reset asserted mid-job SHALL abandon the job, produce no done pulse, and stop further res_we.

Configuration
REQ-029 With macro TILE_SEQ_PERF_EN defined, the block SHALL add output perf_cycles, 32 bits, that counts busy cycles of the last job, saturates at 2^32-1, clears on job accept, and resets to 0.
REQ-030 Without TILE_SEQ_PERF_EN, perf_cycles and its counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-031 Defaults, start with num_rows=8, src_base=0x010, dst_base=0x020, w_sel=1 -> w_addr=1; we_rl for 1 cycle; ub_addr 0x010..0x017 on consecutive cycles; res_we 8 cycles starting 18 cycles after the first ub_rd_en; res_addr 0x020..0x027; done once.
REQ-032 num_rows=4, src_base=0x3FE -> ub_addr sequence 0x3FE, 0x3FF, 0x000, 0x001.
REQ-033 start with num_rows=0 -> err pulse 1 cycle; busy stays 0; no ub_rd_en.
REQ-034 start held high throughout job -> no second acceptance before done; second job starts the cycle after done.
REQ-035 rstn pulsed low during STREAM -> all outputs 0 immediately; no res_we or done afterwards until a new start.
REQ-036 With TILE_SEQ_PERF_EN and num_rows=8 at defaults -> perf_cycles=29 after done.
